l2_cache_control: RTL

- Control FSM for the 4-way, 8-set L2 cache; sits between the L1 miss interface and physical memory.
- Drives the L2 LRU array's `load`/`mru`/`index` inputs and consumes its `lru_out` to pick replacement victims.
- Drives the tag/valid/dirty/data array write strobes; the datapath, with the tag compare and arrays, is external.
- Single outstanding request; write-back, write-allocate.

---
 rtl/l2_types_pkg.sv | 20 ++
 rtl/l2_victim_select.sv | 22 ++
 rtl/l2_cache_control.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/l2_types_pkg.sv
// Shared types and geometry for the 4-way, 8-set L2 cache controller.
// Address split: tag = addr[31:8], index = addr[7:5], offset = addr[4:0].
package l2_types_pkg;

    localparam int OFFSET_BITS = 5;
    localparam int INDEX_BITS  = 3;
    localparam int WAY_BITS    = 2;
    localparam int TAG_BITS    = 24;

    localparam logic DATA_SRC_PMEM = 1'b0;
    localparam logic DATA_SRC_L1   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FILL
    } l2_ctrl_state_t;

endpackage

// File: rtl/l2_victim_select.sv
// Replacement victim choice: lowest-numbered invalid way, else the LRU way.
module l2_victim_select #(
    parameter int WAY_BITS = l2_types_pkg::WAY_BITS
) (
    input  logic [(1<<WAY_BITS)-1:0] valid,
    input  logic [WAY_BITS-1:0]      lru_out,
    output logic [WAY_BITS-1:0]      victim
);

    localparam int NWAYS = 1 << WAY_BITS;

    always_comb begin
        victim = lru_out;
        // Scan downward so the lowest invalid way is the last to win.
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim = WAY_BITS'(w);
            end
        end
    end

endmodule

// File: rtl/l2_cache_control.sv
// Control FSM for the L2 cache: hit handling, victim write-back and line fill.
// Single outstanding request, write-back / write-allocate.
module l2_cache_control #(
    parameter int OFFSET_BITS = l2_types_pkg::OFFSET_BITS,
    parameter int INDEX_BITS  = l2_types_pkg::INDEX_BITS,
    parameter int WAY_BITS    = l2_types_pkg::WAY_BITS
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  l1_read,
    input  logic                                  l1_write,
    input  logic [31:0]                           l1_addr,
    output logic                                  l2_resp,
    input  logic [(1<<WAY_BITS)-1:0]              hit,
    input  logic [(1<<WAY_BITS)-1:0]              valid,
    input  logic [(1<<WAY_BITS)-1:0]              dirty,
    input  logic [31-INDEX_BITS-OFFSET_BITS:0]    victim_tag,
    output logic [WAY_BITS-1:0]                   way_sel,
    output logic                                  tag_load,
    output logic                                  valid_load,
    output logic                                  data_load,
    output logic                                  dirty_load,
    output logic                                  dirty_in,
    output logic                                  data_src,
    output logic                                  lru_load,
    output logic [WAY_BITS-1:0]                   lru_mru,
    output logic [INDEX_BITS-1:0]                 lru_index,
    input  logic [WAY_BITS-1:0]                   lru_out,
    output logic                                  pmem_read,
    output logic                                  pmem_write,
    output logic [31:0]                           pmem_addr,
    input  logic                                  pmem_resp
);

    import l2_types_pkg::*;

    localparam int NWAYS = 1 << WAY_BITS;
    localparam int TAG_W = 32 - INDEX_BITS - OFFSET_BITS;

    l2_ctrl_state_t state_q, state_d;
    logic [WAY_BITS-1:0]   victim_q;
    logic [WAY_BITS-1:0]   victim;
    logic [WAY_BITS-1:0]   hit_way;
    logic                  any_hit;
    logic [TAG_W-1:0]      addr_tag;
    logic [INDEX_BITS-1:0] addr_index;
    logic                  addr_offset_unused;

    assign addr_tag           = l1_addr[31 -: TAG_W];
    assign addr_index         = l1_addr[OFFSET_BITS +: INDEX_BITS];
    assign addr_offset_unused = ^l1_addr[OFFSET_BITS-1:0];
    assign any_hit            = |hit;

    // The set index is an address, not a strobe, but it still reads 0 in reset.
    assign lru_index = rst ? '0 : addr_index;

    l2_victim_select #(
        .WAY_BITS (WAY_BITS)
    ) u_victim_select (
        .valid   (valid),
        .lru_out (lru_out),
        .victim  (victim)
    );

    always_comb begin
        hit_way = '0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (hit[w]) begin
                hit_way = WAY_BITS'(w);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CHECK && !any_hit) begin
                victim_q <= victim;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        l2_resp    = 1'b0;
        way_sel    = '0;
        tag_load   = 1'b0;
        valid_load = 1'b0;
        data_load  = 1'b0;
        dirty_load = 1'b0;
        dirty_in   = 1'b0;
        data_src   = DATA_SRC_PMEM;
        lru_load   = 1'b0;
        lru_mru    = '0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;

        unique case (state_q)
            IDLE: begin
                if (l1_read || l1_write) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (any_hit) begin
                    l2_resp  = 1'b1;
                    lru_load = 1'b1;
                    lru_mru  = hit_way;
                    way_sel  = hit_way;
                    if (l1_write) begin
                        data_load  = 1'b1;
                        data_src   = DATA_SRC_L1;
                        dirty_load = 1'b1;
                        dirty_in   = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    way_sel = victim;
                    state_d = (valid[victim] && dirty[victim]) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                way_sel    = victim_q;
                pmem_write = 1'b1;
                pmem_addr  = {victim_tag, addr_index, {OFFSET_BITS{1'b0}}};
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                way_sel   = victim_q;
                pmem_read = 1'b1;
                pmem_addr = {addr_tag, addr_index, {OFFSET_BITS{1'b0}}};
                if (pmem_resp) begin
                    data_load  = 1'b1;
                    data_src   = DATA_SRC_PMEM;
                    tag_load   = 1'b1;
                    valid_load = 1'b1;
                    dirty_load = 1'b1;
                    dirty_in   = 1'b0;
                    state_d    = CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
